// File: rtl/wb_arbiter.sv
// wb_arbiter: register-file write-back arbiter between a single-cycle ALU and a long-latency unit
//
// Ports:
//   Clk, Rst_n            clock (rising edge), asynchronous active-low reset
//   alu_valid/rd/data     ALU result, one cycle, no backpressure, always wins
//   lu_valid/rd/data      long-latency unit result, handshaked with lu_ready
//   lu_ready              LU result accepted this cycle (buffer not full)
//   wb_en/addr/data       registered register-file write port
//   alu_hold              registered request to upstream to withhold ALU results
//   lu_count              LU buffer occupancy, 0..2
module wb_arbiter #(
  parameter int DATA_WIDTH   = 64,
  parameter int ADDR_WIDTH   = 5,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  alu_valid,
  input  logic [ADDR_WIDTH-1:0] alu_rd,
  input  logic [DATA_WIDTH-1:0] alu_data,
  input  logic                  lu_valid,
  input  logic [ADDR_WIDTH-1:0] lu_rd,
  input  logic [DATA_WIDTH-1:0] lu_data,
  output logic                  lu_ready,
  output logic                  wb_en,
  output logic [ADDR_WIDTH-1:0] wb_addr,
  output logic [DATA_WIDTH-1:0] wb_data,
  output logic                  alu_hold,
  output logic [1:0]            lu_count
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);
  logic [ADDR_WIDTH-1:0] fifo_rd_q [2];
  logic [DATA_WIDTH-1:0] fifo_data_q [2];
  logic rptr_q, wptr_q;
  logic [1:0] cnt_q, cnt_d;
  logic [CW-1:0] starve_q, starve_d;
  logic wb_en_q, wb_en_d;
  logic [ADDR_WIDTH-1:0] wb_addr_q, wb_addr_d;
  logic [DATA_WIDTH-1:0] wb_data_q, wb_data_d;
  logic hold_q, hold_d;
  logic empty, lu_xfer, sel_head, sel_byp, enq, deq;
  // lu_ready is gated by Rst_n so it drops the instant reset asserts
  assign lu_ready = Rst_n & (cnt_q != 2'd2);
  assign empty    = cnt_q == 2'd0;
  assign lu_xfer  = lu_valid & lu_ready;
  assign sel_head = !alu_valid & !empty;
  assign sel_byp  = !alu_valid & empty & lu_xfer;
  assign deq      = sel_head;
  // rd=0 transfers complete the handshake but are dropped here
  assign enq      = lu_xfer & !sel_byp & (lu_rd != '0);
  always_comb begin
    wb_en_d   = alu_valid ? (alu_rd != '0) : (sel_head | (sel_byp & (lu_rd != '0)));
    wb_addr_d = alu_valid ? alu_rd : sel_head ? fifo_rd_q[rptr_q] : lu_rd;
    wb_data_d = alu_valid ? alu_data : sel_head ? fifo_data_q[rptr_q] : lu_data;
    cnt_d     = cnt_q + {1'b0, enq} - {1'b0, deq};
    starve_d  = (deq || empty) ? '0 : (alu_valid && starve_q != LIMIT) ? starve_q + 1'b1 : starve_q;
    hold_d    = starve_d == LIMIT;
  end
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      fifo_rd_q   <= '{default: '0};
      fifo_data_q <= '{default: '0};
      rptr_q      <= 1'b0;
      wptr_q      <= 1'b0;
      cnt_q       <= 2'd0;
      starve_q    <= '0;
      wb_en_q     <= 1'b0;
      wb_addr_q   <= '0;
      wb_data_q   <= '0;
      hold_q      <= 1'b0;
    end else begin
      if (enq) begin
        fifo_rd_q[wptr_q]   <= lu_rd;
        fifo_data_q[wptr_q] <= lu_data;
        wptr_q              <= ~wptr_q;
      end
      if (deq) rptr_q <= ~rptr_q;
      cnt_q    <= cnt_d;
      starve_q <= starve_d;
      hold_q   <= hold_d;
      wb_en_q  <= wb_en_d;
      // address/data hold their last written values when nothing is written
      if (wb_en_d) begin
        wb_addr_q <= wb_addr_d;
        wb_data_q <= wb_data_d;
      end
    end
  end
  assign wb_en    = wb_en_q;
  assign wb_addr  = wb_addr_q;
  assign wb_data  = wb_data_q;
  assign alu_hold = hold_q;
  assign lu_count = cnt_q;
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed table-driven bench for wb_arbiter
module tb_wb_arbiter;
  typedef struct {
    logic        av;
    logic [4:0]  ard;
    logic [63:0] ad;
    logic        lv;
    logic [4:0]  lrd;
    logic [63:0] ld;
    logic        en;
    logic [4:0]  addr;
    logic [63:0] data;
    logic [1:0]  cnt;
    logic        rdy;
    logic        hold;
    logic        cad;
  } vec_t;
  logic Clk = 1'b0;
  logic Rst_n = 1'b0;
  logic alu_valid = 1'b0, lu_valid = 1'b0;
  logic [4:0] alu_rd = '0, lu_rd = '0;
  logic [63:0] alu_data = '0, lu_data = '0;
  logic lu_ready, wb_en, alu_hold;
  logic [4:0] wb_addr;
  logic [63:0] wb_data;
  logic [1:0] lu_count;
  int checks = 0;
  int failures = 0;
  vec_t vq[$];
  wb_arbiter dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .lu_valid(lu_valid), .lu_rd(lu_rd), .lu_data(lu_data),
    .lu_ready(lu_ready), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .alu_hold(alu_hold), .lu_count(lu_count)
  );
  always #5 Clk = ~Clk;
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  task automatic add(input int av, input int ard, input logic [63:0] ad, input int lv, input int lrd,
                     input logic [63:0] ld, input int en, input int addr, input logic [63:0] data,
                     input int cnt, input int rdy, input int hold, input int cad);
    vec_t v;
    v.av = 1'(av); v.ard = 5'(ard); v.ad = ad; v.lv = 1'(lv); v.lrd = 5'(lrd); v.ld = ld;
    v.en = 1'(en); v.addr = 5'(addr); v.data = data; v.cnt = 2'(cnt); v.rdy = 1'(rdy);
    v.hold = 1'(hold); v.cad = 1'(cad);
    vq.push_back(v);
  endtask
  task automatic idle_inputs();
    alu_valid = 0; alu_rd = '0; alu_data = '0; lu_valid = 0; lu_rd = '0; lu_data = '0;
  endtask
  initial begin
    //   av ard ad       lv lrd ld      en addr data     cnt rdy hold cad
    add(1, 5, 'h1234,   0, 0,  0,      1, 5,  'h1234,   0,  1,  0,   1);  // ALU alone
    add(0, 0, 0,        0, 0,  0,      0, 5,  'h1234,   0,  1,  0,   1);  // idle: hold addr/data
    add(0, 0, 0,        1, 7,  'hAA,   1, 7,  'hAA,     0,  1,  0,   1);  // bypass
    add(0, 0, 0,        0, 0,  0,      0, 7,  'hAA,     0,  1,  0,   1);
    add(1, 3, 'h33,     1, 4,  'h44,   1, 3,  'h33,     1,  1,  0,   1);  // collision
    add(0, 0, 0,        0, 0,  0,      1, 4,  'h44,     0,  1,  0,   1);
    add(1, 1, 'h11,     1, 8,  'h88,   1, 1,  'h11,     1,  1,  0,   1);  // fill
    add(1, 2, 'h22,     1, 9,  'h99,   1, 2,  'h22,     2,  0,  0,   1);
    add(1, 3, 'h3,      1, 10, 'hA0,   1, 3,  'h3,      2,  0,  0,   1);  // third LU refused
    add(0, 0, 0,        1, 10, 'hA0,   1, 8,  'h88,     1,  1,  0,   1);  // still refused, head out
    add(0, 0, 0,        1, 10, 'hA0,   1, 9,  'h99,     1,  1,  0,   1);  // deq + enq together
    add(0, 0, 0,        0, 0,  0,      1, 10, 'hA0,     0,  1,  0,   1);
    add(1, 1, 'h1,      1, 11, 'hB,    1, 1,  'h1,      1,  1,  0,   1);  // starvation
    add(1, 2, 'h2,      0, 0,  0,      1, 2,  'h2,      1,  1,  0,   1);
    add(1, 3, 'h3,      0, 0,  0,      1, 3,  'h3,      1,  1,  0,   1);
    add(1, 4, 'h4,      0, 0,  0,      1, 4,  'h4,      1,  1,  0,   1);
    add(1, 5, 'h5,      0, 0,  0,      1, 5,  'h5,      1,  1,  1,   1);  // 4th blocked edge
    add(1, 6, 'h6,      0, 0,  0,      1, 6,  'h6,      1,  1,  1,   1);  // ALU still wins
    add(0, 0, 0,        0, 0,  0,      1, 11, 'hB,      0,  1,  0,   1);  // head out, hold drops
    add(1, 0, 'hDEAD,   0, 0,  0,      0, 0,  0,        0,  1,  0,   0);  // ALU rd=0
    add(0, 0, 0,        1, 0,  'hBEEF, 0, 0,  0,        0,  1,  0,   0);  // bypass rd=0
    add(1, 12, 'hC,     1, 0,  'hF0,   1, 12, 'hC,      0,  1,  0,   1);  // LU rd=0 not enqueued
    add(0, 0, 0,        0, 0,  0,      0, 12, 'hC,      0,  1,  0,   1);
    add(1, 1, 'h1,      1, 13, 'hD,    1, 1,  'h1,      1,  1,  0,   1);  // refill for reset
    add(1, 2, 'h2,      1, 14, 'hE,    1, 2,  'h2,      2,  0,  0,   1);
    #3;
    chk("reset_wb_en", wb_en, 0);
    chk("reset_lu_ready", lu_ready, 0);
    chk("reset_lu_count", lu_count, 0);
    chk("reset_alu_hold", alu_hold, 0);
    @(posedge Clk); #2 Rst_n = 1'b1;
    @(posedge Clk); #1;
    chk("first_edge_lu_ready", lu_ready, 1);
    foreach (vq[i]) begin
      alu_valid = vq[i].av; alu_rd = vq[i].ard; alu_data = vq[i].ad;
      lu_valid = vq[i].lv; lu_rd = vq[i].lrd; lu_data = vq[i].ld;
      @(posedge Clk); #1;
      chk($sformatf("v%0d_wb_en", i), wb_en, vq[i].en);
      chk($sformatf("v%0d_lu_count", i), lu_count, vq[i].cnt);
      chk($sformatf("v%0d_lu_ready", i), lu_ready, vq[i].rdy);
      chk($sformatf("v%0d_alu_hold", i), alu_hold, vq[i].hold);
      if (vq[i].cad) begin
        chk($sformatf("v%0d_wb_addr", i), wb_addr, vq[i].addr);
        chk($sformatf("v%0d_wb_data", i), wb_data, vq[i].data);
      end
    end
    idle_inputs();
    #2 Rst_n = 1'b0;
    #1;
    chk("async_wb_en", wb_en, 0);
    chk("async_wb_addr", wb_addr, 0);
    chk("async_wb_data", wb_data, 0);
    chk("async_lu_count", lu_count, 0);
    chk("async_lu_ready", lu_ready, 0);
    chk("async_alu_hold", alu_hold, 0);
    @(posedge Clk); #1;
    chk("held_wb_en", wb_en, 0);
    chk("held_lu_ready", lu_ready, 0);
    #3 Rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge Clk); #1;
      chk($sformatf("post_rst%0d_wb_en", k), wb_en, 0);
      chk($sformatf("post_rst%0d_lu_count", k), lu_count, 0);
      chk($sformatf("post_rst%0d_lu_ready", k), lu_ready, 1);
    end
    alu_valid = 1; alu_rd = 5'd9; alu_data = 64'h5A5A;
    @(posedge Clk); #1;
    alu_valid = 0;
    chk("post_rst_alu_wb_addr", wb_addr, 9);
    chk("post_rst_alu_wb_data", wb_data, 'h5A5A);
    @(posedge Clk); #1;
    chk("post_rst_idle_wb_en", wb_en, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
